int_to_fp8_arbiter: RTL and testbench

INT_TO_FP8_ARBITER -- requirements
Module: int_to_fp8_arbiter

---
 rtl/int_to_fp8_arbiter.sv | 119 +++++++++++
 tb/tb_int_to_fp8_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_fp8_arbiter.sv
// Round-robin front end that shares one two-stage int-to-FP8 converter among N_REQ requesters.
// Results are tagged with their source id and buffered in a credit-protected in-order FIFO.
module int_to_fp8_arbiter #(
    parameter int INT_BITS   = 20,
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*INT_BITS-1:0]     req_int,
    output logic [N_REQ-1:0]              req_ready,
    output logic [INT_BITS-1:0]           conv_int,
    input  logic [7:0]                    conv_float8,
    output logic                          res_valid,
    output logic [7:0]                    res_fp8,
    output logic [$clog2(N_REQ)-1:0]      res_id,
    input  logic                          res_ready,
    output logic                          busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           tag1_vld_q, tag2_vld_q;
    logic [IDW-1:0] tag1_id_q, tag2_id_q;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic [7:0]     fp_mem [FIFO_DEPTH];
    logic [IDW-1:0] id_mem [FIFO_DEPTH];

    logic           found;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] gnt_id;
    logic [CW:0]    occ;
    logic           credit_ok;
    logic           gnt_any;
    logic           push;
    logic           pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        found  = 1'b0;
        cand   = '0;
        gnt_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr_q + IDW'(k);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
    end

    // Credit counts buffered entries plus results still inside the converter; a same-cycle pop is not credited.
    always_comb begin
        occ       = {1'b0, count_q} + {{CW{1'b0}}, tag1_vld_q} + {{CW{1'b0}}, tag2_vld_q};
        credit_ok = (occ < (CW + 1)'(FIFO_DEPTH));
        gnt_any   = found && credit_ok && !reset;
        req_ready = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
        conv_int  = gnt_any ? req_int[gnt_id*INT_BITS +: INT_BITS] : '0;
    end

    assign res_valid = (count_q != '0);
    assign res_fp8   = res_valid ? fp_mem[rd_ptr_q] : '0;
    assign res_id    = res_valid ? id_mem[rd_ptr_q] : '0;
    assign busy      = tag1_vld_q || tag2_vld_q || res_valid;

    assign push = tag2_vld_q;
    assign pop  = res_valid && res_ready;

    always_comb begin
        ptr_d    = gnt_any ? gnt_id + IDW'(1) : ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            tag1_vld_q <= 1'b0;
            tag2_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            tag1_vld_q <= gnt_any;
            tag2_vld_q <= tag1_vld_q;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Tag ids and FIFO payload only matter when qualified by the valid/count state above.
    always_ff @(posedge clk) begin
        tag1_id_q <= gnt_id;
        tag2_id_q <= tag1_id_q;
        if (push) begin
            fp_mem[wr_ptr_q] <= conv_float8;
            id_mem[wr_ptr_q] <= tag2_id_q;
        end
    end

endmodule

// File: tb/tb_int_to_fp8_arbiter.sv
// Bench for int_to_fp8_arbiter: behavioural two-stage converter, table-driven single requests,
// a source-tagged result scoreboard, and hand-written multi-cycle sequences.
module tb_int_to_fp8_arbiter;

    localparam int INT_BITS   = 20;
    localparam int N_REQ      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int IDW        = $clog2(N_REQ);

    logic                      clk;
    logic                      reset;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*INT_BITS-1:0] req_int;
    logic [N_REQ-1:0]          req_ready;
    logic [INT_BITS-1:0]       conv_int;
    logic [7:0]                conv_float8;
    logic                      res_valid;
    logic [7:0]                res_fp8;
    logic [IDW-1:0]            res_id;
    logic                      res_ready;
    logic                      busy;

    int nchecks = 0;
    int nerrors = 0;

    int_to_fp8_arbiter #(
        .INT_BITS   (INT_BITS),
        .N_REQ      (N_REQ),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_int     (req_int),
        .req_ready   (req_ready),
        .conv_int    (conv_int),
        .conv_float8 (conv_float8),
        .res_valid   (res_valid),
        .res_fp8     (res_fp8),
        .res_id      (res_id),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Converter behaviour: sign in bit 7, exponent = msb_index-3 in bits 6:3, three bits below the msb as mantissa.
    function automatic logic [7:0] fp8_model(input logic [INT_BITS-1:0] x);
        logic                s;
        logic [INT_BITS-1:0] mag;
        int                  m;
        s   = x[INT_BITS-1];
        mag = s ? -x : x;
        if (mag == '0) return 8'h00;
        m = 0;
        for (int b = 0; b < INT_BITS; b++) if (mag[b]) m = b;
        if (m < 4)  return {s, 4'd0, mag[3:1]};
        if (m > 18) return {s, 7'h7F};
        return {s, 4'(m - 3), mag[m-1 -: 3]};
    endfunction

    logic [7:0] cv_stage;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cv_stage    <= 8'h00;
            conv_float8 <= 8'h00;
        end else begin
            cv_stage    <= fp8_model(conv_int);
            conv_float8 <= cv_stage;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [IDW-1:0] id;
        logic [7:0]     fp8;
    } sb_t;
    sb_t sb[$];
    sb_t sb_e;
    logic [INT_BITS-1:0] exp_conv;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            check("req_ready_onehot0", 32'($onehot0(req_ready)), 1);
            exp_conv = '0;
            for (int i = 0; i < N_REQ; i++)
                if (req_ready[i]) exp_conv = req_int[i*INT_BITS +: INT_BITS];
            check("conv_int", conv_int, exp_conv);
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL sb_unexpected: got id %0d fp8 0x%0h, expected no result", res_id, res_fp8);
                end else begin
                    sb_e = sb.pop_front();
                    check("sb_id", res_id, sb_e.id);
                    check("sb_fp8", res_fp8, sb_e.fp8);
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_e.id  = IDW'(i);
                    sb_e.fp8 = fp8_model(req_int[i*INT_BITS +: INT_BITS]);
                    sb.push_back(sb_e);
                end
            end
        end
    end

    typedef struct {
        int                  req;
        logic [INT_BITS-1:0] val;
        logic [7:0]          fp8;
    } vec_t;
    vec_t vecs[9];

    task automatic do_reset();
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = '0;
        req_int   = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_conv_int"}, conv_int, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_fp8"}, res_fp8, 0);
        check({tag, "_res_id"}, res_id, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    int ngr;

    initial begin
        vecs[0] = '{req: 0, val: 20'h00010, fp8: 8'h08};
        vecs[1] = '{req: 0, val: 20'hFFFF0, fp8: 8'h88};
        vecs[2] = '{req: 0, val: 20'h40000, fp8: 8'h78};
        vecs[3] = '{req: 1, val: 20'h00018, fp8: 8'h0C};
        vecs[4] = '{req: 2, val: 20'h7FFFF, fp8: 8'h7F};
        vecs[5] = '{req: 3, val: 20'hFFF9C, fp8: 8'h9C};
        vecs[6] = '{req: 2, val: 20'h00000, fp8: 8'h00};
        vecs[7] = '{req: 1, val: 20'h80000, fp8: 8'hFF};
        vecs[8] = '{req: 3, val: 20'h00005, fp8: 8'h02};

        reset     = 1'b1;
        req_valid = '0;
        req_int   = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single transfers: result exactly three cycles after the grant, for one cycle.
        for (int v = 0; v < 9; v++) begin
            @(posedge clk); #1;
            req_int = '0;
            req_int[vecs[v].req*INT_BITS +: INT_BITS] = vecs[v].val;
            req_valid = N_REQ'(1) << vecs[v].req;
            @(negedge clk);
            check("vec_grant", req_ready, N_REQ'(1) << vecs[v].req);
            @(posedge clk); #1;
            req_valid = '0;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (c == 3) begin
                    check("vec_res_valid", res_valid, 1);
                    check("vec_res_fp8", res_fp8, vecs[v].fp8);
                    check("vec_res_id", res_id, vecs[v].req);
                end else begin
                    check("vec_res_idle", res_valid, 0);
                end
            end
        end

        // Reset with toggling inputs, then grant on the first cycle after release.
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = N_REQ'($urandom);
            for (int i = 0; i < N_REQ; i++) req_int[i*INT_BITS +: INT_BITS] = INT_BITS'($urandom);
            res_ready = 1'($urandom);
            #2 check_all_zero("rst_mid");
            @(negedge clk);
            check_all_zero("rst_neg");
            @(posedge clk); #1;
        end
        reset     = 1'b0;
        req_valid = 4'b0100;
        res_ready = 1'b1;
        @(negedge clk);
        check("rel_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(negedge clk);

        // All four valid from p=0: grants 0..3, results in order three cycles later.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                req_valid = '1;
                for (int i = 0; i < N_REQ; i++) req_int[i*INT_BITS +: INT_BITS] = INT_BITS'(32 * (i + 1) + 7);
            end
            if (c == 4) req_valid = '0;
            @(negedge clk);
            if (c < 4) check("rr_grant", req_ready, N_REQ'(1) << c);
            check("rr_res_valid", res_valid, (c >= 3 && c <= 6) ? 1 : 0);
            if (c >= 3 && c <= 6) check("rr_res_id", res_id, c - 3);
        end

        // Backpressure: credits run out after FIFO_DEPTH grants; one pop frees exactly one grant.
        do_reset();
        res_ready = 1'b0;
        ngr = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                req_valid = 4'b0001;
                req_int[0 +: INT_BITS] = 20'd100;
            end
            @(negedge clk);
            if (req_ready[0]) ngr++;
            if (c >= 4) check("bp_stall", req_ready, 0);
        end
        check("bp_grants", ngr, 4);
        check("bp_busy", busy, 1);
        check("bp_res_valid", res_valid, 1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_cycle", req_ready, 0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("bp_regrant", req_ready, 4'b0001);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_restall", req_ready, 0);
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_drained", busy, 0);

        // Fairness at full throughput: req0 and req2 alternate, one grant per cycle.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                req_valid = 4'b0101;
                req_int[0 +: INT_BITS] = 20'h01234;
                req_int[2*INT_BITS +: INT_BITS] = 20'hFEDCB;
            end
            @(negedge clk);
            check("fair_grant", req_ready, (c % 2 == 0) ? 4'b0001 : 4'b0100);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(negedge clk);

        // Mid-operation reset with two tags in flight and one buffered result.
        do_reset();
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                req_valid = 4'b0001;
                req_int[0 +: INT_BITS] = 20'h00400;
            end
            @(negedge clk);
            check("r25_grant", req_ready, 4'b0001);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("r25_busy_pre", busy, 1);
        check("r25_valid_pre", res_valid, 1);
        #1 reset = 1'b1;
        #2 check_all_zero("r25_rst");
        @(negedge clk);
        @(posedge clk); #1;
        reset     = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("r25_no_result", res_valid, 0);
            check("r25_idle", busy, 0);
        end

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
